// File: rtl/gray_ptr_receiver_pkg.sv
// Shared constants for the async-FIFO convertor family plus a small Gray-step helper.
package gray_ptr_receiver_pkg;

   localparam int DEFAULT_N_BITS      = 4;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // True when more than one bit is set; pointers wider than 32 bits are not supported.
   function automatic logic multiBitStep(input logic [31:0] diff);
      return (diff & (diff - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/gray_ptr_receiver_gray2bin.sv
// Combinational Gray-to-binary converter, inverse partner of the binary-to-Gray encoder.
module gray_ptr_receiver_gray2bin #(
   parameter int n_bits = 4
) (
   input  logic [n_bits-1:0] gray_i,
   output logic [n_bits-1:0] bin_o
);

   // Each binary bit is the XOR of all Gray bits at or above its position.
   for (genvar i = 0; i < n_bits; i++) begin : g_bit
      assign bin_o[i] = ^(gray_i >> i);
   end

endmodule

// File: rtl/gray_ptr_receiver.sv
// Receives a Gray pointer from a foreign domain: synchronises, decodes, derives level and flags bad steps.
module gray_ptr_receiver
   import gray_ptr_receiver_pkg::*;
#(
   parameter int n_bits      = DEFAULT_N_BITS,
   parameter int sync_stages = DEFAULT_SYNC_STAGES
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [n_bits-1:0] grayIn,
   input  logic [n_bits-1:0] localBin,
   input  logic              errClr,
   output logic [n_bits-1:0] binOut,
   output logic              binValid,
   output logic              binUpd,
   output logic [n_bits-1:0] level,
   output logic              grayErr
);

   localparam int FILL_MAX = sync_stages + 1;
   localparam int CNT_W    = $clog2(FILL_MAX + 1);

   logic [n_bits-1:0] sync_q [sync_stages];
   logic [n_bits-1:0] prevGray_q;
   logic [n_bits-1:0] binOut_q,   binOut_d;
   logic [n_bits-1:0] level_q,    level_d;
   logic [CNT_W-1:0]  fillCnt_q,  fillCnt_d;
   logic              binValid_q, binValid_d;
   logic              binUpd_q,   binUpd_d;
   logic              grayErr_q,  grayErr_d;
   logic [n_bits-1:0] syncGray;
   logic [n_bits-1:0] decoded;
   logic [n_bits-1:0] grayDiff;
   logic              stepIllegal;

   assign syncGray = sync_q[sync_stages-1];

   gray_ptr_receiver_gray2bin #(
      .n_bits (n_bits)
   ) u_gray2bin (
      .gray_i (syncGray),
      .bin_o  (decoded)
   );

   // The error check uses the current binValid so the first decoded value after reset is never judged.
   always_comb begin
      fillCnt_d = fillCnt_q;
      if (fillCnt_q != CNT_W'(FILL_MAX)) begin
         fillCnt_d = fillCnt_q + CNT_W'(1);
      end
      binValid_d  = (fillCnt_d == CNT_W'(FILL_MAX));
      binOut_d    = decoded;
      level_d     = localBin - decoded;
      binUpd_d    = binValid_d & (decoded != binOut_q);
      grayDiff    = syncGray ^ prevGray_q;
      stepIllegal = binValid_q & multiBitStep(32'(grayDiff));
      grayErr_d   = grayErr_q;
      if (errClr) begin
         grayErr_d = 1'b0;
      end
      if (stepIllegal) begin
         grayErr_d = 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int k = 0; k < sync_stages; k++) begin
            sync_q[k] <= '0;
         end
         prevGray_q <= '0;
         binOut_q   <= '0;
         level_q    <= '0;
         fillCnt_q  <= '0;
         binValid_q <= 1'b0;
         binUpd_q   <= 1'b0;
         grayErr_q  <= 1'b0;
      end else begin
         sync_q[0] <= grayIn;
         for (int k = 1; k < sync_stages; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         prevGray_q <= syncGray;
         binOut_q   <= binOut_d;
         level_q    <= level_d;
         fillCnt_q  <= fillCnt_d;
         binValid_q <= binValid_d;
         binUpd_q   <= binUpd_d;
         grayErr_q  <= grayErr_d;
      end
   end

   assign binOut   = binOut_q;
   assign binValid = binValid_q;
   assign binUpd   = binUpd_q;
   assign level    = level_q;
   assign grayErr  = grayErr_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Directed bench for gray_ptr_receiver: each stimulus row queues its hand-computed post-edge outputs for a monitor.
module tb_gray_ptr_receiver;

   logic       ACLK;
   logic       ARESET;
   logic [3:0] grayIn;
   logic [3:0] localBin;
   logic       errClr;
   logic [3:0] binOut;
   logic       binValid;
   logic       binUpd;
   logic [3:0] level;
   logic       grayErr;

   typedef struct {
      int         rowId;
      logic [3:0] eBin;
      logic       eValid;
      logic       eUpd;
      logic [3:0] eLevel;
      logic       eErr;
   } expect_t;

   expect_t expQ [$];
   int      compared   = 0;
   int      mismatched = 0;
   int      rowNum     = 0;

   gray_ptr_receiver #(
      .n_bits      (4),
      .sync_stages (2)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .grayIn   (grayIn),
      .localBin (localBin),
      .errClr   (errClr),
      .binOut   (binOut),
      .binValid (binValid),
      .binUpd   (binUpd),
      .level    (level),
      .grayErr  (grayErr)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Drives one cycle of inputs on the falling edge and queues what the outputs must be after the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] g, input logic [3:0] loc,
                                input logic clr, input logic [3:0] eBin, input logic eValid,
                                input logic eUpd, input logic [3:0] eLevel, input logic eErr);
      expect_t e;
      @(negedge ACLK);
      ARESET   = rst;
      grayIn   = g;
      localBin = loc;
      errClr   = clr;
      rowNum++;
      e.rowId  = rowNum;
      e.eBin   = eBin;
      e.eValid = eValid;
      e.eUpd   = eUpd;
      e.eLevel = eLevel;
      e.eErr   = eErr;
      expQ.push_back(e);
   endtask

   task automatic checkField(input string name, input int rowId, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s row %0d: got %0d, expected %0d", name, rowId, act, exp);
      end
   endtask

   task automatic checkOutput(input expect_t e);
      checkField("binOut",   e.rowId, int'(binOut),   int'(e.eBin));
      checkField("binValid", e.rowId, int'(binValid), int'(e.eValid));
      checkField("binUpd",   e.rowId, int'(binUpd),   int'(e.eUpd));
      checkField("level",    e.rowId, int'(level),    int'(e.eLevel));
      checkField("grayErr",  e.rowId, int'(grayErr),  int'(e.eErr));
   endtask

   // Monitor: after every rising edge, pop one pending expectation and compare.
   initial begin
      expect_t e;
      forever begin
         @(posedge ACLK);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      ARESET   = 1'b1;
      grayIn   = 4'b0000;
      localBin = 4'd0;
      errClr   = 1'b0;

      // Reset, then hold Gray 0110 (binary 4): valid and a single update pulse on the third edge.
      applyStimulus(1, 4'b0110, 4'd0,  0,  4'd0, 0, 0, 4'd0,  0);
      applyStimulus(1, 4'b0110, 4'd0,  0,  4'd0, 0, 0, 4'd0,  0);
      applyStimulus(0, 4'b0110, 4'd0,  0,  4'd0, 0, 0, 4'd0,  0);
      applyStimulus(0, 4'b0110, 4'd0,  0,  4'd0, 0, 0, 4'd0,  0);
      applyStimulus(0, 4'b0110, 4'd0,  0,  4'd4, 1, 1, 4'd12, 0);
      applyStimulus(0, 4'b0110, 4'd0,  0,  4'd4, 1, 0, 4'd12, 0);
      applyStimulus(0, 4'b0110, 4'd0,  0,  4'd4, 1, 0, 4'd12, 0);

      // Re-reset onto Gray 13, then count 14, 15, wrap to 0, 1.
      applyStimulus(1, 4'b1011, 4'd0,  0,  4'd0,  0, 0, 4'd0,  0);
      applyStimulus(0, 4'b1011, 4'd0,  0,  4'd0,  0, 0, 4'd0,  0);
      applyStimulus(0, 4'b1011, 4'd0,  0,  4'd0,  0, 0, 4'd0,  0);
      applyStimulus(0, 4'b1001, 4'd0,  0,  4'd13, 1, 1, 4'd3,  0);
      applyStimulus(0, 4'b1000, 4'd0,  0,  4'd13, 1, 0, 4'd3,  0);
      applyStimulus(0, 4'b0000, 4'd0,  0,  4'd14, 1, 1, 4'd2,  0);
      applyStimulus(0, 4'b0001, 4'd0,  0,  4'd15, 1, 1, 4'd1,  0);
      applyStimulus(0, 4'b0001, 4'd0,  0,  4'd0,  1, 1, 4'd0,  0);
      applyStimulus(0, 4'b0001, 4'd0,  0,  4'd1,  1, 1, 4'd15, 0);
      applyStimulus(0, 4'b0001, 4'd0,  0,  4'd1,  1, 0, 4'd15, 0);

      // Level against the local pointer: 2-14 wraps to 4, then 14-14 = 0.
      applyStimulus(0, 4'b1001, 4'd2,  0,  4'd1,  1, 0, 4'd1,  0);
      applyStimulus(0, 4'b1001, 4'd2,  0,  4'd1,  1, 0, 4'd1,  0);
      applyStimulus(0, 4'b1001, 4'd2,  0,  4'd14, 1, 1, 4'd4,  0);
      applyStimulus(0, 4'b1001, 4'd14, 0,  4'd14, 1, 0, 4'd0,  0);
      applyStimulus(0, 4'b1001, 4'd14, 0,  4'd14, 1, 0, 4'd0,  0);

      // Walk legally to Gray 0000, then jump to 0011 (two bits): sticky error, then clear.
      applyStimulus(0, 4'b1000, 4'd0,  0,  4'd14, 1, 0, 4'd2,  0);
      applyStimulus(0, 4'b0000, 4'd0,  0,  4'd14, 1, 0, 4'd2,  0);
      applyStimulus(0, 4'b0000, 4'd0,  0,  4'd15, 1, 1, 4'd1,  0);
      applyStimulus(0, 4'b0011, 4'd0,  0,  4'd0,  1, 1, 4'd0,  0);
      applyStimulus(0, 4'b0011, 4'd0,  0,  4'd0,  1, 0, 4'd0,  0);
      applyStimulus(0, 4'b0011, 4'd0,  0,  4'd2,  1, 1, 4'd14, 1);
      applyStimulus(0, 4'b0011, 4'd0,  0,  4'd2,  1, 0, 4'd14, 1);
      applyStimulus(0, 4'b0011, 4'd0,  1,  4'd2,  1, 0, 4'd14, 0);
      applyStimulus(0, 4'b0011, 4'd0,  0,  4'd2,  1, 0, 4'd14, 0);

      // Illegal 0011 -> 0101 with errClr in the same cycle: set wins.
      applyStimulus(0, 4'b0101, 4'd0,  0,  4'd2,  1, 0, 4'd14, 0);
      applyStimulus(0, 4'b0101, 4'd0,  0,  4'd2,  1, 0, 4'd14, 0);
      applyStimulus(0, 4'b0101, 4'd0,  1,  4'd6,  1, 1, 4'd10, 1);
      applyStimulus(0, 4'b0101, 4'd0,  0,  4'd6,  1, 0, 4'd10, 1);
      applyStimulus(0, 4'b0101, 4'd0,  1,  4'd6,  1, 0, 4'd10, 0);

      // Reach binOut = 9, reset mid-stream, re-acquire without a spurious error.
      applyStimulus(0, 4'b1101, 4'd0,  0,  4'd6,  1, 0, 4'd10, 0);
      applyStimulus(0, 4'b1101, 4'd0,  0,  4'd6,  1, 0, 4'd10, 0);
      applyStimulus(0, 4'b1101, 4'd0,  0,  4'd9,  1, 1, 4'd7,  0);
      applyStimulus(0, 4'b1101, 4'd0,  0,  4'd9,  1, 0, 4'd7,  0);
      applyStimulus(1, 4'b1101, 4'd5,  0,  4'd0,  0, 0, 4'd0,  0);
      applyStimulus(0, 4'b1101, 4'd5,  0,  4'd0,  0, 0, 4'd5,  0);
      applyStimulus(0, 4'b1101, 4'd5,  0,  4'd0,  0, 0, 4'd5,  0);
      applyStimulus(0, 4'b1101, 4'd5,  0,  4'd9,  1, 1, 4'd12, 0);
      applyStimulus(0, 4'b1101, 4'd5,  0,  4'd9,  1, 0, 4'd12, 0);
      applyStimulus(0, 4'b1101, 4'd5,  0,  4'd9,  1, 0, 4'd12, 0);

      for (int i = 0; i < 8 && expQ.size() != 0; i++) begin
         @(posedge ACLK);
      end
      #2;
      if (expQ.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
